test_mailbox: RTL and testbench



---
 rtl/test_mailbox.sv | 179 +++++++++++++++++
 tb/tb_test_mailbox.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_mailbox.sv
// rtl/test_mailbox.sv - memory-mapped test mailbox: check commands, pass/fail counters, done/failed latches
// Optional feature macro: TEST_MAILBOX_WATCHDOG_EN (CYCLE counter and watchdog halt).
module test_mailbox #(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned EXEC_CYCLES = 2,
    parameter int unsigned MAX_CYCLES  = 2048,
    parameter logic [31:0] DONE_CODE   = 32'h0D15EA5E,
    parameter logic [31:0] FAIL_CODE   = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strobe,
    output logic [31:0]           rd_data,
    output logic                  access_fault,
    output logic                  busy,
    output logic                  done,
    output logic                  failed,
    output logic [15:0]           pass_count,
    output logic [15:0]           fail_count
);

`ifdef TEST_MAILBOX_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, HALTED} state_t;

    state_t                state, state_next;
    logic [31:0]           arg0, arg1, last_cmd, cycle;
    logic                  timeout, last_pass;
    logic [CW-1:0]         exec_cnt;

    logic [ADDR_WIDTH-3:0] widx;
    logic [2:0]            wsel;
    logic                  mapped, is_cmd, is_arg0, is_arg1, is_ro;
    logic                  accept, fault, wr_ok, rd_ok;
    logic                  cmd_start, exec_fire, wd_trip;
    logic [31:0]           rdata_mux;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];
    assign busy = (state == EXEC);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Address decode and access qualification; only word offsets 0x00-0x1C exist.
    always_comb begin
        widx    = addr[ADDR_WIDTH-1:2];
        wsel    = widx[2:0];
        mapped  = (32'(widx) < 32'd8);
        is_cmd  = mapped && (wsel == 3'd0);
        is_arg0 = mapped && (wsel == 3'd1);
        is_arg1 = mapped && (wsel == 3'd2);
        is_ro   = mapped && (wsel >= 3'd3);
        accept  = !busy && (rd_en || wr_en);
        fault   = accept && ((rd_en && wr_en) || !mapped || (wr_en && is_ro) ||
                  (wr_en && is_cmd && ((wr_strobe != 4'hF) || (state == HALTED))));
        wr_ok   = accept && wr_en && !fault;
        rd_ok   = accept && rd_en && !fault;
        case (wsel)
            3'd1:    rdata_mux = arg0;
            3'd2:    rdata_mux = arg1;
            3'd3:    rdata_mux = {28'b0, timeout, last_pass, done, failed};
            3'd4:    rdata_mux = {16'b0, pass_count};
            3'd5:    rdata_mux = {16'b0, fail_count};
            3'd6:    rdata_mux = cycle;
            3'd7:    rdata_mux = last_cmd;
            default: rdata_mux = 32'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        cmd_start  = 1'b0;
        exec_fire  = 1'b0;
        wd_trip    = WD_EN && (state != HALTED) && (cycle == 32'(MAX_CYCLES - 1));
        case (state)
            IDLE: begin
                if (wr_ok && is_cmd) begin
                    cmd_start  = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exec_cnt == '0) begin
                    exec_fire  = 1'b1;
                    state_next = ((last_cmd == DONE_CODE) || (last_cmd == FAIL_CODE)) ? HALTED : IDLE;
                end
            end
            default: ;
        endcase
        // Watchdog wins: any in-flight or just-issued command is abandoned.
        if (wd_trip) begin
            state_next = HALTED;
            cmd_start  = 1'b0;
            exec_fire  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data      <= '0;
            access_fault <= 1'b0;
            done         <= 1'b0;
            failed       <= 1'b0;
            pass_count   <= '0;
            fail_count   <= '0;
            arg0         <= '0;
            arg1         <= '0;
            last_cmd     <= '0;
            cycle        <= '0;
            timeout      <= 1'b0;
            last_pass    <= 1'b0;
            exec_cnt     <= '0;
        end else begin
            access_fault <= fault;
            if (rd_ok) begin
                rd_data <= rdata_mux;
            end
            for (int b = 0; b < 4; b++) begin
                if (wr_ok && is_arg0 && wr_strobe[b]) arg0[8*b +: 8] <= wr_data[8*b +: 8];
                if (wr_ok && is_arg1 && wr_strobe[b]) arg1[8*b +: 8] <= wr_data[8*b +: 8];
            end
            if (cmd_start) begin
                last_cmd <= wr_data;
                exec_cnt <= CW'(EXEC_CYCLES - 1);
            end else if (busy && (exec_cnt != '0)) begin
                exec_cnt <= exec_cnt - 1'b1;
            end
            if (exec_fire) begin
                if (last_cmd == DONE_CODE) begin
                    done <= 1'b1;
                end else if (last_cmd == FAIL_CODE) begin
                    failed     <= 1'b1;
                    fail_count <= sat_inc(fail_count);
                end else if (last_cmd == 32'd0) begin
                    if (arg0 == arg1) begin
                        pass_count <= sat_inc(pass_count);
                        last_pass  <= 1'b1;
                    end else begin
                        fail_count <= sat_inc(fail_count);
                        last_pass  <= 1'b0;
                    end
                end else if (last_cmd == 32'd1) begin
                    fail_count <= sat_inc(fail_count);
                    last_pass  <= 1'b0;
                end else begin
                    fail_count <= sat_inc(fail_count);
                end
            end
            if (WD_EN && (state != HALTED) && (cycle != 32'hFFFF_FFFF)) begin
                cycle <= cycle + 32'd1;
            end
            if (wd_trip) begin
                timeout <= 1'b1;
                failed  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_test_mailbox.sv
// tb/tb_test_mailbox.sv - randomized self-checking bench for test_mailbox against a transaction-level model
module tb_test_mailbox;

    localparam int unsigned EXEC_CYCLES = 2;
    localparam int unsigned WD_MAX      = 5000;
    localparam logic [31:0] DONE_CODE   = 32'h0D15EA5E;
    localparam logic [31:0] FAIL_CODE   = 32'hDEADBEEF;
`ifdef TEST_MAILBOX_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [5:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strobe = '0;
    logic [31:0] rd_data;
    logic        access_fault, busy, done, failed;
    logic [15:0] pass_count, fail_count;

    test_mailbox #(
        .ADDR_WIDTH(6), .EXEC_CYCLES(EXEC_CYCLES), .MAX_CYCLES(WD_MAX),
        .DONE_CODE(DONE_CODE), .FAIL_CODE(FAIL_CODE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
        .access_fault(access_fault), .busy(busy), .done(done), .failed(failed),
        .pass_count(pass_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: a command's effect is applied when it is accepted,
    // since the next access cannot be accepted before the command completes.
    logic [31:0] m_arg0, m_arg1, m_last_cmd, m_rd, m_cycle;
    logic [15:0] m_pass, m_fail;
    bit          m_done, m_failed, m_last_pass, m_timeout, m_halted;

    function automatic logic [15:0] inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic model_reset();
        m_arg0 = 0; m_arg1 = 0; m_last_cmd = 0; m_rd = 0; m_cycle = 0;
        m_pass = 0; m_fail = 0;
        m_done = 0; m_failed = 0; m_last_pass = 0; m_timeout = 0; m_halted = 0;
    endtask

    task automatic model_cmd(input logic [31:0] code);
        m_last_cmd = code;
        if (code == DONE_CODE) begin
            m_done = 1; m_halted = 1;
        end else if (code == FAIL_CODE) begin
            m_failed = 1; m_fail = inc16(m_fail); m_halted = 1;
        end else if (code == 0) begin
            if (m_arg0 == m_arg1) begin m_pass = inc16(m_pass); m_last_pass = 1; end
            else begin m_fail = inc16(m_fail); m_last_pass = 0; end
        end else if (code == 1) begin
            m_fail = inc16(m_fail); m_last_pass = 0;
        end else begin
            m_fail = inc16(m_fail);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] off);
        case (off)
            6'h04:   return m_arg0;
            6'h08:   return m_arg1;
            6'h0C:   return {28'b0, m_timeout, m_last_pass, m_done, m_failed};
            6'h10:   return {16'b0, m_pass};
            6'h14:   return {16'b0, m_fail};
            6'h18:   return m_cycle;
            6'h1C:   return m_last_cmd;
            default: return 32'b0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_flags();
        check("done", done, m_done);
        check("failed", failed, m_failed);
        check("pass_count", pass_count, m_pass);
        check("fail_count", fail_count, m_fail);
    endtask

    // Present one request, hold it while busy, then check fault and read data.
    task automatic access(input bit r, input bit w, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int held, output bit ef);
        logic [5:0] off;
        @(negedge clk);
        rd_en = r; wr_en = w; addr = a; wr_data = d; wr_strobe = s;
        held = 0;
        while (busy && held < 50) begin
            @(negedge clk);
            held++;
        end
        if (held >= 50) check("busy_timeout", 32'd1, 32'd0);
        check_flags();
        off = a & 6'h3C;
        ef = (r && w) || (off > 6'h1C) || (w && off >= 6'h0C) ||
             (w && off == 6'h00 && (s != 4'hF || m_halted));
        if (!ef) begin
            if (r) m_rd = model_read(off);
            else if (off == 6'h00) model_cmd(d);
            else begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b] && off == 6'h04) m_arg0[8*b +: 8] = d[8*b +: 8];
                    if (s[b] && off == 6'h08) m_arg1[8*b +: 8] = d[8*b +: 8];
                end
            end
        end
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        check("access_fault", access_fault, ef);
        check("rd_data", rd_data, m_rd);
    endtask

    task automatic count_busy();
        int n;
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", n, EXEC_CYCLES);
    endtask

    initial begin
        int h;
        bit f;
        logic [5:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        do_reset();
        check("rst_rd_data", rd_data, 0);
        check("rst_fault", access_fault, 0);
        check("rst_busy", busy, 0);
        check_flags();
        access(1, 0, 6'h0C, 0, 0, h, f);

        // Passing CHECK_EQ, then failing CHECK_EQ with a read held across busy
        access(0, 1, 6'h04, 32'h1234, 4'hF, h, f);
        access(0, 1, 6'h08, 32'h1234, 4'hF, h, f);
        access(0, 1, 6'h00, 32'h0, 4'hF, h, f);
        count_busy();
        access(1, 0, 6'h0C, 0, 0, h, f);
        access(0, 1, 6'h08, 32'h1235, 4'hF, h, f);
        access(0, 1, 6'h00, 32'h0, 4'hF, h, f);
        access(1, 0, 6'h14, 0, 0, h, f);
        check("read_held_during_busy", 32'(h > 0), 1);
        access(1, 0, 6'h0C, 0, 0, h, f);

        // Fault cases, followed by reads proving nothing changed
        access(0, 1, 6'h00, 32'h1, 4'h3, h, f);
        access(0, 1, 6'h10, 32'h55, 4'hF, h, f);
        access(1, 0, 6'h24, 0, 0, h, f);
        access(1, 1, 6'h04, 32'hFFFF, 4'hF, h, f);
        access(1, 0, 6'h04, 0, 0, h, f);
        access(1, 0, 6'h1C, 0, 0, h, f);
        access(0, 1, 6'h04, 32'hA5A5_5A5A, 4'h5, h, f);
        access(1, 0, 6'h04, 0, 0, h, f);

        // DONE halts; CMD writes then fault, ARG writes still work
        access(0, 1, 6'h00, DONE_CODE, 4'hF, h, f);
        count_busy();
        access(1, 0, 6'h0C, 0, 0, h, f);
        access(0, 1, 6'h00, 32'h0, 4'hF, h, f);
        access(0, 1, 6'h08, 32'hCAFE, 4'hF, h, f);
        access(1, 0, 6'h08, 0, 0, h, f);

        // Reset while a command executes discards it
        do_reset();
        access(0, 1, 6'h00, 32'h1, 4'hF, h, f);
        do_reset();
        check("midexec_fail_count", fail_count, 0);
        check("midexec_busy", busy, 0);
        access(1, 0, 6'h1C, 0, 0, h, f);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int kind;
            if (m_halted && $urandom_range(0, 7) == 0) do_reset();
            kind = $urandom_range(0, 9);
            a = 6'($urandom_range(0, 63));
            if ((a & 6'h3C) == 6'h18) a = 6'h1C;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            case (kind)
                0, 1, 2: access(1, 0, a, 0, 0, h, f);
                3: access(0, 1, 6'h04, d, s, h, f);
                4: begin
                    if ($urandom_range(0, 1) == 1) access(0, 1, 6'h08, m_arg0, 4'hF, h, f);
                    else access(0, 1, 6'h08, d, s, h, f);
                end
                5, 6: begin
                    int pick;
                    pick = $urandom_range(0, 19);
                    if (pick < 8) d = 0;
                    else if (pick < 12) d = 1;
                    else if (pick == 12) d = DONE_CODE;
                    else if (pick == 13) d = FAIL_CODE;
                    if ($urandom_range(0, 7) != 0) s = 4'hF;
                    access(0, 1, 6'h00, d, s, h, f);
                    if (!f && $urandom_range(0, 1) == 1) count_busy();
                end
                7: access(0, 1, a, d, s, h, f);
                8: access(1, 1, a, d, s, h, f);
                default: access(1, 0, 6'h0C, 0, 0, h, f);
            endcase
        end

        // Watchdog: idle past the limit with no commands
        do_reset();
        repeat (WD_MAX + 10) @(negedge clk);
        if (WD_EN) begin
            m_failed = 1; m_timeout = 1; m_halted = 1; m_cycle = WD_MAX;
        end
        access(1, 0, 6'h18, 0, 0, h, f);
        access(1, 0, 6'h0C, 0, 0, h, f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
